// File: rtl/demux4_tdm_rx.sv
// demux4_tdm_rx: serial TDM receiver that demultiplexes 4 slots into d1..d4.
// Optional feature macro: DEMUX_PARITY_EN adds a 5th slot carrying even parity
// over slots 0..3; a frame that fails the check is dropped with a parity_err pulse.
module demux4_tdm_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       sync,
  input  logic       en,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4,
  output logic       frame_valid,
  output logic       sync_err,
  output logic       parity_err,
  output logic [2:0] slot
);

`ifdef DEMUX_PARITY_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic [2:0] slot_nxt;
  logic [3:0] shadow, shadow_nxt;   // bit i holds slot i of the frame in flight
  logic [3:0] dout, dout_nxt;       // bit i drives d(i+1)
  logic       fv_nxt, se_nxt, pe_nxt;

  // State, slot counter, shadow/output registers and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= '0;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      shadow      <= shadow_nxt;
      dout        <= dout_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= se_nxt;
      parity_err  <= pe_nxt;
    end
  end

  // Next-state logic: everything holds and pulses drop unless en samples a slot.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    shadow_nxt = shadow;
    dout_nxt   = dout;
    fv_nxt     = 1'b0;
    se_nxt     = 1'b0;
    pe_nxt     = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          // Data before the first sync is meaningless and dropped.
          if (sync) begin
            shadow_nxt[0] = din;
            slot_nxt      = 3'd1;
            state_nxt     = RUN;
          end
        end
        RUN: begin
          if (sync && slot != 3'd0) begin
            // Misplaced sync: abandon the partial frame and realign on it.
            se_nxt        = 1'b1;
            shadow_nxt[0] = din;
            slot_nxt      = 3'd1;
          end else begin
            // Only data slots are stored; the parity slot is consumed in-flight.
            if (slot <= 3'd3)
              shadow_nxt[slot[1:0]] = din;
            if (slot == LAST) begin
              slot_nxt = 3'd0;
`ifdef DEMUX_PARITY_EN
              if (^{shadow, din}) begin
                pe_nxt = 1'b1;
              end else begin
                dout_nxt = shadow;
                fv_nxt   = 1'b1;
              end
`else
              dout_nxt = shadow_nxt;
              fv_nxt   = 1'b1;
`endif
            end else begin
              slot_nxt = slot + 3'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign d1 = dout[0];
  assign d2 = dout[1];
  assign d3 = dout[2];
  assign d4 = dout[3];

endmodule

// File: tb/tb_demux4_tdm_rx.sv
// Directed bench for demux4_tdm_rx; builds with or without DEMUX_PARITY_EN.
module tb_demux4_tdm_rx;
  logic       clk = 1'b0;
  logic       rst_n, din, sync, en;
  logic       d1, d2, d3, d4, frame_valid, sync_err, parity_err;
  logic [2:0] slot;
  int         checks = 0;
  int         errors = 0;

  demux4_tdm_rx dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .frame_valid(frame_valid), .sync_err(sync_err), .parity_err(parity_err),
    .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, then settle 1 time unit past the rising edge.
  task automatic cyc(input logic d, input logic s, input logic e);
    @(negedge clk);
    din = d; sync = s; en = e;
    @(posedge clk);
    #1;
  endtask

  // b[3] goes to slot 0 (d1) ... b[0] to slot 3 (d4); bad_par flips the parity bit.
  task automatic frame(input logic [3:0] b, input logic s, input logic bad_par);
    cyc(b[3], s, 1'b1);
    cyc(b[2], 1'b0, 1'b1);
    cyc(b[1], 1'b0, 1'b1);
    cyc(b[0], 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    cyc(b[3] ^ b[2] ^ b[1] ^ b[0] ^ bad_par, 1'b0, 1'b1);
`else
    if (bad_par) $display("note: parity flip ignored in 4-slot build");
`endif
  endtask

  function automatic logic [3:0] dv();
    return {d1, d2, d3, d4};
  endfunction

  initial begin
    rst_n = 1'b0; din = 1'b0; sync = 1'b0; en = 1'b0;
    #22;
    chk("rst_d", dv(), 4'b0000);
    chk("rst_slot", slot, 3'd0);
    chk("rst_pulses", {frame_valid, sync_err, parity_err}, 3'b000);
    @(negedge clk); rst_n = 1'b1;

    // Basic frame 1011
    cyc(1'b1, 1'b1, 1'b1);
    chk("f1_slot1", slot, 3'd1);
    chk("f1_nofv", frame_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    chk("f1_slot4", slot, 3'd4);
    chk("f1_nofv_early", frame_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
`endif
    chk("f1_fv", frame_valid, 1'b1);
    chk("f1_d", dv(), 4'b1011);
    chk("f1_slot0", slot, 3'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("f1_fv_pulse", frame_valid, 1'b0);
    chk("f1_hold", dv(), 4'b1011);

    // Back-to-back frames, sync only on the first
    frame(4'b1000, 1'b1, 1'b0);
    chk("b2b_fv1", frame_valid, 1'b1);
    chk("b2b_d1", dv(), 4'b1000);
    frame(4'b0001, 1'b0, 1'b0);
    chk("b2b_fv2", frame_valid, 1'b1);
    chk("b2b_d2", dv(), 4'b0001);

    // Misplaced sync at slot 2 restarts the frame
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("se_pre_slot", slot, 3'd2);
    cyc(1'b0, 1'b1, 1'b1);
    chk("se_pulse", sync_err, 1'b1);
    chk("se_slot", slot, 3'd1);
    chk("se_nofv", frame_valid, 1'b0);
    chk("se_hold", dv(), 4'b0001);
    cyc(1'b1, 1'b0, 1'b1);
    chk("se_drop", sync_err, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    cyc(1'b0, 1'b0, 1'b1);   // parity of 0,1,1,0
`endif
    chk("se_new_fv", frame_valid, 1'b1);
    chk("se_new_d", dv(), 4'b0110);

    // en gaps between every slot, frame 1101
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("gap_slot", slot, 3'd1);
    chk("gap_quiet", {frame_valid, sync_err}, 2'b00);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gap_nofv", frame_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
`endif
    chk("gap_fv", frame_valid, 1'b1);
    chk("gap_d", dv(), 4'b1101);

`ifdef DEMUX_PARITY_EN
    // Parity mismatch drops the frame; correct parity updates
    frame(4'b1100, 1'b1, 1'b1);
    chk("par_err", parity_err, 1'b1);
    chk("par_nofv", frame_valid, 1'b0);
    chk("par_hold", dv(), 4'b1101);
    frame(4'b1100, 1'b1, 1'b0);
    chk("par_ok_pe", parity_err, 1'b0);
    chk("par_ok_fv", frame_valid, 1'b1);
    chk("par_ok_d", dv(), 4'b1100);
`endif

    // Asynchronous reset at slot 2
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("ar_pre_slot", slot, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_d", dv(), 4'b0000);
    chk("ar_slot", slot, 3'd0);
    chk("ar_pulses", {frame_valid, sync_err, parity_err}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    frame(4'b1111, 1'b0, 1'b0);
    chk("ar_ign_fv", frame_valid, 1'b0);
    chk("ar_ign_d", dv(), 4'b0000);
    chk("ar_ign_slot", slot, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
